io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Consumer for the core's IO output port: captures every 32-bit word the core writes to IO address 0 (the dout / dout_ready pair).
- Buffers those words in a small FIFO and serialises each one as four UART 8N1 bytes, least significant byte first, on a single tx line.
- The core cannot stall, so the block never back-pressures; words arriving while the FIFO is full are dropped and flagged.
- Sits at the top level next to core; core.dout -> din, core.dout_ready -> din_valid.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 2.
- FIFO_DEPTH, 8, word entries in the FIFO; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  32  word to transmit, sampled when din_valid=1.
- din_valid  input  1  single-cycle write strobe from the core.
- tx  output  1  UART serial output, idle high.
- busy  output  1  1 while the FIFO is non-empty or a frame is in progress.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset (async, immediate): tx=1, busy=0, overflow=0, fifo_count=0; FIFO pointers cleared; FSM to IDLE; baud counter and byte index cleared. Reset mid-frame aborts the frame and discards all queued data.
- FIFO write:
  - On a clk edge with din_valid=1 and the FIFO not full, din is written.
  - If the FIFO is full and no pop occurs on the same edge, the word is dropped and overflow is set to 1 until reset.
  - A write and a pop on the same edge are both performed, including when the FIFO is full; the count is unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: if the FIFO is non-empty, pop the head into a 32-bit shift register, set byte index=0, go to START. The pop happens on that same edge.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - byte index < 3: increment the index, shift the word right by 8, go to START.
    - byte index = 3 and FIFO non-empty: pop the next word and go directly to START (no idle gap).
    - otherwise: go to IDLE.
- tx is driven from a register (glitch-free).
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reset to 0 on every state entry. Every bit lasts exactly CLKS_PER_BIT cycles.
- Latency: a word written on edge E0 into an empty, idle block is popped on edge E1, and tx is low from E1.
- Word duration: 40*CLKS_PER_BIT cycles (44*CLKS_PER_BIT with parity).
- busy = (state != IDLE) | (fifo_count != 0), registered-consistent with fifo_count; it falls on the edge the last STOP bit completes.
- fifo_count never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro IO_TX_PARITY_EN.
- When defined: a PARITY state follows DATA, lasting CLKS_PER_BIT cycles, with tx = even parity (XOR of the 8 data bits). The frame is 11 bits (8E1).
- When undefined: no PARITY state and no parity logic; 8N1 frames of 10 bits.

Test Plan:
- Basic word: CLKS_PER_BIT=4, din=0xA5C30F81 pulsed at edge 0 -> tx low from edge 1; bytes 0x81, 0x0F, 0xC3, 0xA5 in that order, each start=0 and stop=1, every bit 4 cycles; busy=0 after 160 cycles; overflow=0.
- Back-to-back: two words on consecutive cycles -> 80 bit-times of continuous framing with no idle gap between the words; fifo_count peaks at 1.
- Overflow: FIFO_DEPTH=8, ten words w0..w9 on edges 0..9 -> w0 popped at edge 1; after edge 8 fifo_count=8; w9 dropped and overflow=1; exactly w0..w8 appear on tx.
- Simultaneous write/pop at full: FIFO full, din_valid pulsed on the edge a word is popped -> word accepted, fifo_count stays 8, overflow stays 0.
- Reset mid-frame: assert reset asynchronously during byte 2 of a word with 3 words queued -> tx=1, busy=0, fifo_count=0, overflow=0 immediately, without waiting for a clk edge; a new word after release transmits normally.
- Parity (IO_TX_PARITY_EN defined): din=0x00000007 -> byte 0x07 parity bit=1, bytes 0x00 parity bit=0; word spans 44*CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/io_uart_tx.sv
// io_uart_tx
// ----------
// Collects the 32-bit words the core writes to IO address 0 and sends each one
// out on a UART line as four bytes, least significant byte first.
//
// Write handshake: din_valid is a one-cycle strobe with no ready signal. A word
// is taken on any rising clk edge where din_valid=1 and the FIFO has room, or
// where the FIFO is full but a word is popped on that same edge. Otherwise the
// word is lost and the sticky overflow flag is set.
//
// Optional feature: define IO_TX_PARITY_EN to add an even-parity bit after the
// data bits. Frames are then 8E1 (11 bits) instead of 8N1 (10 bits).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    FIFO size in words (power of two, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   din         word to send, sampled when din_valid=1
//   din_valid   one-cycle write strobe
//   tx          UART serial output, idles high, driven from a flop
//   busy        high while the FIFO holds words or a frame is in progress
//   overflow    sticky: a word was dropped because the FIFO was full
//   fifo_count  number of words in the FIFO
//   state_dbg   current serialiser state, for debug and checkers
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   din,
  input  logic                          din_valid,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef IO_TX_PARITY_EN
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
`else
    ST_STOP   = 3'd3
`endif
  } state_e;

  // Registered state
  state_e         state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [31:0]    shreg_q, shreg_d;
  logic           tx_q, tx_d;
  logic           overflow_q, overflow_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [31:0]    mem_q [FIFO_DEPTH];

  logic           fifo_empty;
  logic           fifo_full;
  logic           pop;
  logic           push;
  logic           bit_done;
  logic [31:0]    head;
  logic [7:0]     cur_byte;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign head       = mem_q[rd_ptr_q];
  assign bit_done   = (baud_q == BAUD_LAST);

  // Serialiser next-state logic. The baud counter restarts at 0 on every
  // state entry, so each bit lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = head;
          byte_idx_d = 2'd0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef IO_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef IO_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          baud_d = '0;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shreg_d    = {8'h00, shreg_q[31:8]};
            state_d    = ST_START;
          end else if (!fifo_empty) begin
            // Chain straight into the next word with no idle bit.
            pop        = 1'b1;
            shreg_d    = head;
            byte_idx_d = 2'd0;
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // tx is computed from the next state so the registered line changes on the
  // same edge the state does.
  always_comb begin
    cur_byte = shreg_d[7:0];
    tx_d     = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = cur_byte[bit_idx_d];
`ifdef IO_TX_PARITY_EN
      ST_PARITY: tx_d = ^cur_byte;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping. A write on a full FIFO is still accepted when a pop
  // frees the slot on the same edge.
  always_comb begin
    push       = din_valid & (~fifo_full | pop);
    overflow_d = overflow_q | (din_valid & fifo_full & ~pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign tx         = tx_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE) | (count_q != '0);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Testbench for io_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=8.
module tb_io_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 8;
`ifdef IO_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WORD_CYC = 4 * FRAME * C;

  // Clock and reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [3:0]  fifo_count;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  io_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference model: a word queue plus the edge on which
  // the transmitter becomes free again (each word occupies WORD_CYC edges).
  logic [31:0] m_fifo[$];
  logic [31:0] exp_q[$];
  int          m_edge = 0;
  int          m_free_at = 0;
  logic        m_ovf = 1'b0;
  logic        m_busy = 1'b0;
  logic [3:0]  m_cnt = '0;
  bit          m_pop;

  initial begin
    forever begin
      @(posedge clk);
      m_edge++;
      if (reset) begin
        m_fifo.delete();
        m_free_at = 0;
        m_ovf = 1'b0;
      end else begin
        m_pop = (m_fifo.size() > 0) && (m_edge >= m_free_at);
        if (m_pop) begin
          exp_q.push_back(m_fifo.pop_front());
          m_free_at = m_edge + WORD_CYC;
        end
        if (din_valid) begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(din);
          else m_ovf = 1'b1;
        end
      end
      m_cnt  = 4'(m_fifo.size());
      m_busy = (m_edge < m_free_at) || (m_cnt != 0);
    end
  end

  // Line monitor: decodes frames, checks every bit holds for C cycles and
  // start/stop/parity levels, and logs start times.
  logic [7:0] rx_bytes[$];
  int         start_cyc[$];
  logic       par_q[$];
  int         frame_err = 0;
  logic       mon_v, mon_ok, mon_abort;
  logic [7:0] mon_byte;

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        start_cyc.push_back(cyc);
        mon_ok = 1'b1; mon_abort = 1'b0; mon_byte = '0; mon_v = 1'b0;
        for (int b = 0; b < FRAME && !mon_abort; b++) begin
          for (int c = 0; c < C; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (reset !== 1'b0) begin mon_abort = 1'b1; break; end
            if (c == 0) mon_v = tx;
            else if (tx !== mon_v) mon_ok = 1'b0;
          end
          if (!mon_abort) begin
            if (b == 0) begin
              if (mon_v !== 1'b0) mon_ok = 1'b0;
            end else if (b <= 8) begin
              mon_byte[b-1] = mon_v;
            end else if (b == FRAME - 1) begin
              if (mon_v !== 1'b1) mon_ok = 1'b0;
            end else begin
              par_q.push_back(mon_v);
              if (mon_v !== ^mon_byte) mon_ok = 1'b0;
            end
          end
        end
        if (!mon_abort) begin
          rx_bytes.push_back(mon_byte);
          if (!mon_ok) frame_err++;
        end
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_bytes.delete(); start_cyc.delete(); par_q.delete(); exp_q.delete();
    frame_err = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_checks++; if (fifo_count !== 4'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({tx, busy} !== 2'b10) begin n_errors++; $display("FAIL reset_idle got tx/busy=%b exp=10", {tx, busy}); end
  endtask

  task automatic test_basic();
    logic [31:0] rw;
    int e0, fall;
    @(negedge clk); din = 32'hA5C30F81; din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0; e0 = cyc;
    n_checks++; if ({tx, fifo_count} !== {1'b1, 4'd1}) begin n_errors++; $display("FAIL basic_e0 got tx=%b cnt=%0d exp tx=1 cnt=1", tx, fifo_count); end
    @(negedge clk);
    n_checks++; if ({tx, busy, fifo_count} !== {1'b0, 1'b1, 4'd0}) begin n_errors++; $display("FAIL basic_e1 got tx=%b busy=%b cnt=%0d exp 0 1 0", tx, busy, fifo_count); end
    for (int i = 0; i < WORD_CYC + 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, m_cnt}) begin n_errors++; $display("FAIL basic_track cyc=%0d got busy/ovf/cnt=%b/%b/%0d exp %b/%b/%0d", cyc, busy, overflow, fifo_count, m_busy, m_ovf, m_cnt); end
      if (!busy && !m_busy) break;
    end
    fall = cyc;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_drain got busy=%b exp=0", busy); end
    n_checks++; if (fall !== e0 + 1 + WORD_CYC) begin n_errors++; $display("FAIL basic_duration got=%0d exp=%0d", fall - e0, 1 + WORD_CYC); end
    n_checks++; if (start_cyc.size() != 4) begin n_errors++; $display("FAIL basic_nbytes got=%0d exp=4", start_cyc.size()); end
    else begin
      n_checks++; if (start_cyc[0] != e0 + 1) begin n_errors++; $display("FAIL basic_latency got=%0d exp=%0d", start_cyc[0], e0 + 1); end
      n_checks++; if (start_cyc[3] - start_cyc[0] != 3 * FRAME * C) begin n_errors++; $display("FAIL basic_spacing got=%0d exp=%0d", start_cyc[3] - start_cyc[0], 3 * FRAME * C); end
    end
    n_checks++; if (frame_err != 0) begin n_errors++; $display("FAIL basic_framing got=%0d exp=0", frame_err); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
    if (rx_bytes.size() == 4) begin
      rw = {rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]};
      n_checks++; if (rw !== 32'hA5C30F81) begin n_errors++; $display("FAIL basic_word got=%h exp=a5c30f81", rw); end
      n_checks++; if (rx_bytes[0] !== 8'h81) begin n_errors++; $display("FAIL basic_byte0 got=%h exp=81", rx_bytes[0]); end
    end else begin
      n_checks++; n_errors++; $display("FAIL basic_rx got=%0d bytes exp=4", rx_bytes.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1, rw;
    logic [3:0] peak;
    do_reset();
    w0 = $urandom; w1 = $urandom; peak = '0;
    @(negedge clk); din = w0; din_valid = 1'b1;
    @(negedge clk); din = w1;
    @(negedge clk); din_valid = 1'b0;
    for (int i = 0; i < 2 * WORD_CYC + 20; i++) begin
      if (fifo_count > peak) peak = fifo_count;
      @(negedge clk);
      n_checks++;
      if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, m_cnt}) begin n_errors++; $display("FAIL b2b_track cyc=%0d got busy/ovf/cnt=%b/%b/%0d exp %b/%b/%0d", cyc, busy, overflow, fifo_count, m_busy, m_ovf, m_cnt); end
      if (!busy && !m_busy) break;
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got busy=%b exp=0", busy); end
    n_checks++; if (peak !== 4'd1) begin n_errors++; $display("FAIL b2b_peak got=%0d exp=1", peak); end
    n_checks++; if (start_cyc.size() != 8) begin n_errors++; $display("FAIL b2b_nbytes got=%0d exp=8", start_cyc.size()); end
    else begin
      n_checks++; if (start_cyc[7] - start_cyc[0] != 7 * FRAME * C) begin n_errors++; $display("FAIL b2b_gap got=%0d exp=%0d", start_cyc[7] - start_cyc[0], 7 * FRAME * C); end
    end
    n_checks++; if (frame_err != 0) begin n_errors++; $display("FAIL b2b_framing got=%0d exp=0", frame_err); end
    if (rx_bytes.size() == 8) begin
      rw = {rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]};
      n_checks++; if (rw !== w0) begin n_errors++; $display("FAIL b2b_w0 got=%h exp=%h", rw, w0); end
      rw = {rx_bytes[7], rx_bytes[6], rx_bytes[5], rx_bytes[4]};
      n_checks++; if (rw !== w1) begin n_errors++; $display("FAIL b2b_w1 got=%h exp=%h", rw, w1); end
    end else begin
      n_checks++; n_errors++; $display("FAIL b2b_rx got=%0d bytes exp=8", rx_bytes.size());
    end
  endtask

  task automatic test_overflow();
    logic [31:0] wv[10];
    logic [31:0] rw;
    do_reset();
    for (int i = 0; i < 10; i++) wv[i] = $urandom;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        n_checks++; if (fifo_count !== 4'd8) begin n_errors++; $display("FAIL ovf_full got=%0d exp=8", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
      din = wv[i]; din_valid = 1'b1;
    end
    @(negedge clk); din_valid = 1'b0;
    n_checks++; if ({overflow, fifo_count} !== {1'b1, 4'd8}) begin n_errors++; $display("FAIL ovf_drop got ovf=%b cnt=%0d exp ovf=1 cnt=8", overflow, fifo_count); end
    for (int i = 0; i < 9 * WORD_CYC + 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, m_cnt}) begin n_errors++; $display("FAIL ovf_track cyc=%0d got busy/ovf/cnt=%b/%b/%0d exp %b/%b/%0d", cyc, busy, overflow, fifo_count, m_busy, m_ovf, m_cnt); end
      if (!busy && !m_busy) break;
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ovf_drain got busy=%b exp=0", busy); end
    n_checks++; if (rx_bytes.size() != 36) begin n_errors++; $display("FAIL ovf_nbytes got=%0d exp=36", rx_bytes.size()); end
    for (int k = 0; k < 9 && rx_bytes.size() >= 4; k++) begin
      rw = {rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]};
      repeat (4) rx_bytes.delete(0);
      n_checks++; if (rw !== wv[k]) begin n_errors++; $display("FAIL ovf_word%0d got=%h exp=%h", k, rw, wv[k]); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    n_checks++; if (frame_err != 0) begin n_errors++; $display("FAIL ovf_framing got=%0d exp=0", frame_err); end
  endtask

  task automatic test_simul_write_pop();
    logic [31:0] wv[10];
    logic [31:0] rw;
    int p;
    do_reset();
    for (int i = 0; i < 10; i++) wv[i] = $urandom;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); din = wv[i]; din_valid = 1'b1;
    end
    @(negedge clk); din_valid = 1'b0;
    // cyc is now the index of the edge that took wv[8]; wv[1] pops one word later
    p = (cyc - 8) + 1 + WORD_CYC;
    while (cyc < p - 1) begin
      @(negedge clk);
      n_checks++;
      if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, m_cnt}) begin n_errors++; $display("FAIL simul_track cyc=%0d got busy/ovf/cnt=%b/%b/%0d exp %b/%b/%0d", cyc, busy, overflow, fifo_count, m_busy, m_ovf, m_cnt); end
    end
    n_checks++; if (fifo_count !== 4'd8) begin n_errors++; $display("FAIL simul_full got=%0d exp=8", fifo_count); end
    din = wv[9]; din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    n_checks++; if ({overflow, fifo_count} !== {1'b0, 4'd8}) begin n_errors++; $display("FAIL simul_edge got ovf=%b cnt=%0d exp ovf=0 cnt=8", overflow, fifo_count); end
    for (int i = 0; i < 9 * WORD_CYC + 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, m_cnt}) begin n_errors++; $display("FAIL simul_track cyc=%0d got busy/ovf/cnt=%b/%b/%0d exp %b/%b/%0d", cyc, busy, overflow, fifo_count, m_busy, m_ovf, m_cnt); end
      if (!busy && !m_busy) break;
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL simul_drain got busy=%b exp=0", busy); end
    n_checks++; if (rx_bytes.size() != 40) begin n_errors++; $display("FAIL simul_nbytes got=%0d exp=40", rx_bytes.size()); end
    for (int k = 0; k < 10 && rx_bytes.size() >= 4; k++) begin
      rw = {rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]};
      repeat (4) rx_bytes.delete(0);
      n_checks++; if (rw !== wv[k]) begin n_errors++; $display("FAIL simul_word%0d got=%h exp=%h", k, rw, wv[k]); end
    end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL simul_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w, rw;
    int target;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); din = $urandom; din_valid = 1'b1;
    end
    @(negedge clk); din_valid = 1'b0;
    // middle of a data bit in byte 2 of the first word
    target = (cyc - 3) + 1 + 2 * FRAME * C + 3 * C + 1;
    while (cyc < target) @(negedge clk);
    n_checks++; if ({busy, fifo_count} !== {1'b1, 4'd3}) begin n_errors++; $display("FAIL rstmid_pre got busy=%b cnt=%0d exp busy=1 cnt=3", busy, fifo_count); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_errors++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (fifo_count !== 4'd0) begin n_errors++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL rstmid_ovf got=%b exp=0", overflow); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_bytes.delete(); start_cyc.delete(); par_q.delete(); exp_q.delete(); frame_err = 0;
    w = $urandom;
    @(negedge clk); din = w; din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    for (int i = 0; i < WORD_CYC + 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, m_cnt}) begin n_errors++; $display("FAIL rstmid_track cyc=%0d got busy/ovf/cnt=%b/%b/%0d exp %b/%b/%0d", cyc, busy, overflow, fifo_count, m_busy, m_ovf, m_cnt); end
      if (!busy && !m_busy) break;
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_drain got busy=%b exp=0", busy); end
    if (rx_bytes.size() == 4) begin
      rw = {rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]};
      n_checks++; if (rw !== w) begin n_errors++; $display("FAIL rstmid_word got=%h exp=%h", rw, w); end
    end else begin
      n_checks++; n_errors++; $display("FAIL rstmid_rx got=%0d bytes exp=4", rx_bytes.size());
    end
    n_checks++; if (frame_err != 0) begin n_errors++; $display("FAIL rstmid_framing got=%0d exp=0", frame_err); end
  endtask

  task automatic test_random();
    logic [31:0] rw, ew;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 120)) begin
        @(negedge clk);
        n_checks++;
        if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, m_cnt}) begin n_errors++; $display("FAIL rand_track cyc=%0d got busy/ovf/cnt=%b/%b/%0d exp %b/%b/%0d", cyc, busy, overflow, fifo_count, m_busy, m_ovf, m_cnt); end
      end
      @(negedge clk); din = $urandom; din_valid = 1'b1;
      @(negedge clk); din_valid = 1'b0;
    end
    for (int i = 0; i < 12 * WORD_CYC + 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, m_cnt}) begin n_errors++; $display("FAIL rand_track cyc=%0d got busy/ovf/cnt=%b/%b/%0d exp %b/%b/%0d", cyc, busy, overflow, fifo_count, m_busy, m_ovf, m_cnt); end
      if (!busy && !m_busy) break;
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rand_drain got busy=%b exp=0", busy); end
    n_checks++; if (rx_bytes.size() != 4 * exp_q.size()) begin n_errors++; $display("FAIL rand_nwords got=%0d bytes exp=%0d", rx_bytes.size(), 4 * exp_q.size()); end
    while (rx_bytes.size() >= 4 && exp_q.size() > 0) begin
      rw = {rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]};
      repeat (4) rx_bytes.delete(0);
      ew = exp_q.pop_front();
      n_checks++; if (rw !== ew) begin n_errors++; $display("FAIL rand_word got=%h exp=%h", rw, ew); end
    end
    n_checks++; if (frame_err != 0) begin n_errors++; $display("FAIL rand_framing got=%0d exp=0", frame_err); end
  endtask

`ifdef IO_TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    @(negedge clk); din = 32'h00000007; din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    for (int i = 0; i < WORD_CYC + 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL par_drain got busy=%b exp=0", busy); end
    n_checks++; if (par_q.size() != 4) begin n_errors++; $display("FAIL par_count got=%0d exp=4", par_q.size()); end
    else begin
      n_checks++; if ({par_q[0], par_q[1], par_q[2], par_q[3]} !== 4'b1000) begin n_errors++; $display("FAIL par_bits got=%b exp=1000", {par_q[0], par_q[1], par_q[2], par_q[3]}); end
    end
    n_checks++; if (frame_err != 0) begin n_errors++; $display("FAIL par_framing got=%0d exp=0", frame_err); end
  endtask
`endif

  // Sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_simul_write_pop();
    test_reset_mid_frame();
    test_random();
`ifdef IO_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d exp=finish before timeout", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
